mkio_bc_control: RTL and testbench

Bus-controller (initiator) end of the MKIO channel, complementing the remote-terminal subaddress controllers.
- On a host start, builds and transmits a command word through the Manchester encoder.
- Sends or collects up to 32 data words through a local 32x16 buffer.
- Validates the RT status word under a response timeout.
- Reports completion, errors and the status word to the host.

---
 rtl/mkio_bc_control_pkg.sv | 41 ++++
 rtl/mkio_bc_buf.sv | 29 ++
 rtl/mkio_bc_control.sv | 238 +++++++++++++++++++++++
 tb/tb_mkio_bc_control.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mkio_bc_control_pkg.sv
// Shared definitions for the MKIO bus-controller: FSM states, command/status
// field positions, sync-type constants and word-count helper.
package mkio_bc_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_TXD,
        S_WSTAT,
        S_RXD,
        S_FIN
    } bc_state_t;

    // Encoder handshake phases for one transmitted word
    typedef enum logic [1:0] {
        TP_FETCH,
        TP_LOAD,
        TP_HI,
        TP_LO
    } tx_phase_t;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned BUF_AW      = 5;

    localparam int unsigned ADDR_MSB    = 15;
    localparam int unsigned ADDR_LSB    = 11;
    localparam int unsigned TR_BIT      = 10;
    localparam int unsigned SA_MSB      = 9;
    localparam int unsigned SA_LSB      = 5;
    localparam int unsigned WC_MSB      = 4;
    localparam int unsigned WC_LSB      = 0;
    localparam int unsigned MSG_ERR_BIT = 10;

    localparam logic CD_CMD  = 1'b0;
    localparam logic CD_DATA = 1'b1;

    function automatic logic [5:0] word_total(input logic [4:0] wc);
        return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
    endfunction

endpackage

// File: rtl/mkio_bc_buf.sv
// 32x16 message buffer: internal write/read port for the controller, host
// write/read port; internal write wins a same-cycle collision.
module mkio_bc_buf
    import mkio_bc_control_pkg::*;
(
    input  logic                clk,
    input  logic                int_we,
    input  logic [BUF_AW-1:0]   int_addr,
    input  logic [WORD_W-1:0]   int_wdata,
    output logic [WORD_W-1:0]   int_rdata,
    input  logic                host_we,
    input  logic [BUF_AW-1:0]   host_addr,
    input  logic [WORD_W-1:0]   host_wdata,
    output logic [WORD_W-1:0]   host_rdata
);

    logic [WORD_W-1:0] mem [32];

    always_ff @(posedge clk) begin
        if (int_we) begin
            mem[int_addr] <= int_wdata;
        end else if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        int_rdata  <= mem[int_addr];
        host_rdata <= mem[host_addr];
    end

endmodule

// File: rtl/mkio_bc_control.sv
// MKIO bus-controller: sends command (+ data), checks RT status, collects data.
// Optional single retry on timeout/parity failure: define MKIO_BC_RETRY_EN.
module mkio_bc_control
    import mkio_bc_control_pkg::*;
#(
    parameter logic [15:0] RESP_TIMEOUT = 16'd224,
    parameter logic [15:0] WORD_TIMEOUT = 16'd400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  subaddr,
    input  logic        tr,
    input  logic [4:0]  word_cnt,
    input  logic        buf_we,
    input  logic [4:0]  buf_addr,
    input  logic [15:0] buf_wdata,
    output logic [15:0] buf_rdata,
    output logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    input  logic        tx_busy,
    input  logic        rx_done,
    input  logic [15:0] rx_data,
    input  logic        rx_cd,
    input  logic        p_error,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_parity,
    output logic        err_proto,
    output logic [15:0] status_word
`ifdef MKIO_BC_RETRY_EN
    ,
    output logic        retried
`endif
);

    bc_state_t   state, state_d;
    tx_phase_t   phase, phase_d;
    logic [5:0]  idx, idx_d;
    logic [15:0] timer, timer_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] status_d;
    logic        err_timeout_d, err_parity_d, err_proto_d;
    logic        fail_timeout, fail_parity;
    logic        int_we;
    logic [15:0] rd_word;
    logic [5:0]  n;
`ifdef MKIO_BC_RETRY_EN
    logic        retried_d;
`endif

    assign n    = word_total(cmd_q[WC_MSB:WC_LSB]);
    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);

    mkio_bc_buf u_buf (
        .clk        (clk),
        .int_we     (int_we),
        .int_addr   (idx[4:0]),
        .int_wdata  (rx_data),
        .int_rdata  (rd_word),
        .host_we    (buf_we && !busy),
        .host_addr  (buf_addr),
        .host_wdata (buf_wdata),
        .host_rdata (buf_rdata)
    );

    always_comb begin
        state_d       = state;
        phase_d       = phase;
        idx_d         = idx;
        timer_d       = timer;
        cmd_d         = cmd_q;
        status_d      = status_word;
        err_timeout_d = err_timeout;
        err_parity_d  = err_parity;
        err_proto_d   = err_proto;
`ifdef MKIO_BC_RETRY_EN
        retried_d     = retried;
`endif
        fail_timeout  = 1'b0;
        fail_parity   = 1'b0;
        int_we        = 1'b0;
        tx_ready      = 1'b0;
        tx_data       = '0;
        tx_cd         = CD_CMD;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_CMD;
                    phase_d       = TP_FETCH;
                    idx_d         = '0;
                    timer_d       = '0;
                    cmd_d         = {rt_addr, tr, subaddr, word_cnt};
                    status_d      = '0;
                    err_timeout_d = 1'b0;
                    err_parity_d  = 1'b0;
                    err_proto_d   = 1'b0;
`ifdef MKIO_BC_RETRY_EN
                    retried_d     = 1'b0;
`endif
                end
            end
            S_CMD, S_TXD: begin
                // FETCH gives the registered buffer read a cycle to follow idx
                tx_cd   = (state == S_TXD) ? CD_DATA : CD_CMD;
                tx_data = (state == S_TXD) ? rd_word : cmd_q;
                case (phase)
                    TP_FETCH: phase_d = TP_LOAD;
                    TP_LOAD: begin
                        if (!tx_busy) begin
                            tx_ready = 1'b1;
                            phase_d  = TP_HI;
                        end
                    end
                    TP_HI: begin
                        if (tx_busy) phase_d = TP_LO;
                    end
                    TP_LO: begin
                        if (!tx_busy) begin
                            phase_d = TP_FETCH;
                            if (state == S_CMD) begin
                                idx_d   = '0;
                                timer_d = '0;
                                state_d = cmd_q[TR_BIT] ? S_WSTAT : S_TXD;
                            end else begin
                                idx_d = idx + 6'd1;
                                if (idx + 6'd1 == n) begin
                                    timer_d = '0;
                                    state_d = S_WSTAT;
                                end
                            end
                        end
                    end
                endcase
            end
            S_WSTAT: begin
                if (rx_done) begin
                    if (p_error) begin
                        fail_parity = 1'b1;
                    end else begin
                        status_d = rx_data;
                        if (rx_cd == CD_CMD && !rx_data[MSG_ERR_BIT] &&
                            rx_data[ADDR_MSB:ADDR_LSB] == cmd_q[ADDR_MSB:ADDR_LSB]) begin
                            if (cmd_q[TR_BIT]) begin
                                state_d = S_RXD;
                                timer_d = '0;
                                idx_d   = '0;
                            end else begin
                                state_d = S_FIN;
                            end
                        end else begin
                            err_proto_d = 1'b1;
                            state_d     = S_FIN;
                        end
                    end
                end else if (timer >= RESP_TIMEOUT) begin
                    fail_timeout = 1'b1;
                end else begin
                    timer_d = timer + 16'd1;
                end
            end
            S_RXD: begin
                if (rx_done) begin
                    timer_d = '0;
                    if (p_error) begin
                        fail_parity = 1'b1;
                    end else if (rx_cd != CD_DATA) begin
                        err_proto_d = 1'b1;
                        state_d     = S_FIN;
                    end else begin
                        int_we = 1'b1;
                        idx_d  = idx + 6'd1;
                        if (idx + 6'd1 == n) state_d = S_FIN;
                    end
                end else if (timer >= WORD_TIMEOUT) begin
                    fail_timeout = 1'b1;
                end else begin
                    timer_d = timer + 16'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fail_timeout || fail_parity) begin
`ifdef MKIO_BC_RETRY_EN
            if (!retried) begin
                retried_d = 1'b1;
                state_d   = S_CMD;
                phase_d   = TP_FETCH;
                idx_d     = '0;
                timer_d   = '0;
            end else
`endif
            begin
                err_timeout_d = err_timeout || fail_timeout;
                err_parity_d  = err_parity || fail_parity;
                state_d       = S_FIN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= TP_FETCH;
            idx         <= '0;
            timer       <= '0;
            cmd_q       <= '0;
            status_word <= '0;
            err_timeout <= 1'b0;
            err_parity  <= 1'b0;
            err_proto   <= 1'b0;
`ifdef MKIO_BC_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            phase       <= phase_d;
            idx         <= idx_d;
            timer       <= timer_d;
            cmd_q       <= cmd_d;
            status_word <= status_d;
            err_timeout <= err_timeout_d;
            err_parity  <= err_parity_d;
            err_proto   <= err_proto_d;
`ifdef MKIO_BC_RETRY_EN
            retried     <= retried_d;
`endif
        end
    end

endmodule

// File: tb/tb_mkio_bc_control.sv
// Directed bench for mkio_bc_control: encoder/RT emulation, transaction-level
// model of transmitted words, buffer contents and completion flags.
module tb_mkio_bc_control;

    localparam logic [15:0] RESP_TO = 16'd224;
    localparam logic [15:0] WORD_TO = 16'd400;
    localparam int ENC_LEN = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  rt_addr = '0, subaddr = '0, word_cnt = '0;
    logic        tr = 1'b0;
    logic        buf_we = 1'b0;
    logic [4:0]  buf_addr = '0;
    logic [15:0] buf_wdata = '0;
    logic [15:0] buf_rdata;
    logic        tx_ready, tx_cd;
    logic [15:0] tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_done = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_cd = 1'b0;
    logic        p_error = 1'b0;
    logic        busy, done, err_timeout, err_parity, err_proto;
    logic [15:0] status_word;
`ifdef MKIO_BC_RETRY_EN
    logic        retried;
`endif

    always #5 clk = ~clk;

    mkio_bc_control #(.RESP_TIMEOUT(RESP_TO), .WORD_TIMEOUT(WORD_TO)) dut (
        .clk(clk), .reset(reset), .start(start), .rt_addr(rt_addr), .subaddr(subaddr),
        .tr(tr), .word_cnt(word_cnt), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_cd(tx_cd), .tx_busy(tx_busy), .rx_done(rx_done),
        .rx_data(rx_data), .rx_cd(rx_cd), .p_error(p_error), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_parity(err_parity), .err_proto(err_proto),
        .status_word(status_word)
`ifdef MKIO_BC_RETRY_EN
        , .retried(retried)
`endif
    );

    int          checks = 0, errors = 0;
    int          cyc = 0;
    logic [16:0] exp_q[$];          // {cd, data} in transmit order
    logic [15:0] model_mem [32];
    logic        exp_active = 1'b0, done_seen = 1'b0;
    logic        exp_to, exp_par, exp_pro;
    logic [15:0] exp_status, first_tx;
    int          done_cyc = 0, last_fall = 0, rx_cyc = 0;
    int          tx_seen = 0, words_done = 0, exp_words = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nwords(input logic [4:0] wc);
        return (wc == 0) ? 32 : int'(wc);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Encoder: sees the load strobe, goes busy after that edge, finishes ENC_LEN edges later
    initial forever begin
        @(negedge clk);
        if (tx_ready) begin
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (ENC_LEN) @(posedge clk);
            #1 tx_busy = 1'b0;
            last_fall = cyc;
            words_done++;
        end
    end

    // Compare process
    initial forever begin
        logic [16:0] e;
        @(negedge clk);
        if (!reset && tx_ready) begin
            tx_seen++;
            if (tx_seen == 1) first_tx = tx_data;
            check("tx_while_busy", tx_busy, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0h/cd%0d expected no word", tx_data, tx_cd);
            end else begin
                e = exp_q.pop_front();
                check("tx_word", {tx_cd, tx_data}, e);
            end
        end
        if (!reset && done) begin
            if (!exp_active) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got 1 expected 0");
            end else begin
                check("err_timeout", err_timeout, exp_to);
                check("err_parity", err_parity, exp_par);
                check("err_proto", err_proto, exp_pro);
                check("status_word", status_word, exp_status);
                check("tx_remaining", exp_q.size(), 0);
            end
            exp_active = 1'b0;
            done_seen  = 1'b1;
            done_cyc   = cyc;
        end
    end

    task automatic start_txn(input logic [4:0] rt, input logic [4:0] sa, input logic t,
                             input logic [4:0] wc);
        int n = nwords(wc);
        exp_q.delete();
        exp_q.push_back({1'b0, rt, t, sa, wc});
        if (!t) for (int i = 0; i < n; i++) exp_q.push_back({1'b1, model_mem[i]});
        exp_words  = exp_q.size();
        words_done = 0;
        tx_seen    = 0;
        exp_to = 1'b0; exp_par = 1'b0; exp_pro = 1'b0; exp_status = '0;
        done_seen  = 1'b0;
        exp_active = 1'b1;
        @(negedge clk);
        rt_addr = rt; subaddr = sa; tr = t; word_cnt = wc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_tx_drained();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (words_done == exp_words) return;
        end
        checks++;
        errors++;
        $display("FAIL tx_drain_timeout: got %0d words expected %0d", words_done, exp_words);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_seen) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
    endtask

    task automatic rx_word(input logic [15:0] d, input logic cd, input logic pe);
        @(negedge clk);
        rx_done = 1'b1; rx_data = d; rx_cd = cd; p_error = pe;
        rx_cyc = cyc;
        @(negedge clk);
        rx_done = 1'b0; p_error = 1'b0;
    endtask

    task automatic host_write(input int a, input logic [15:0] d, input logic accepted);
        @(negedge clk);
        buf_we = 1'b1; buf_addr = a[4:0]; buf_wdata = d;
        @(negedge clk);
        buf_we = 1'b0;
        if (accepted) model_mem[a] = d;
    endtask

    task automatic read_check(input int a);
        @(negedge clk);
        buf_addr = a[4:0];
        @(negedge clk);
        check($sformatf("buf_rd[%0d]", a), buf_rdata, model_mem[a]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_parity", err_parity, 0);
        check("rst_err_proto", err_proto, 0);
        check("rst_status", status_word, 0);
        check("rst_tx_data", {tx_cd, tx_data}, 0);
        reset = 1'b0;

        host_write(0, 16'hA5A5, 1'b1);
        host_write(1, 16'h5A5A, 1'b1);
        for (int i = 2; i < 32; i++) host_write(i, 16'h1000 + 16'(i), 1'b1);
        read_check(1);

        // BC->RT, two words; host write during busy must be dropped
        start_txn(5'd1, 5'd3, 1'b0, 5'd2);
        check("busy_after_start", busy, 1);
        host_write(5, 16'hDEAD, 1'b0);
        wait_tx_drained();
        repeat (3) @(negedge clk);
        exp_status = 16'h0800;
        rx_word(16'h0800, 1'b0, 1'b0);
        wait_done(500);
        check("cmd_bc_rt", first_tx, 16'h0862);
        check("status_bc_rt", status_word, 16'h0800);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);

        // RT->BC, three words
        start_txn(5'd1, 5'd5, 1'b1, 5'd3);
        wait_tx_drained();
        repeat (2) @(negedge clk);
        exp_status = 16'h0800;
        rx_word(16'h0800, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_mem[i] = 16'(i + 1);
            rx_word(16'(i + 1), 1'b1, 1'b0);
        end
        wait_done(500);
        check("cmd_rt_bc", first_tx, 16'h0CA3);
        for (int i = 0; i < 3; i++) read_check(i);
        read_check(5);

        // No status: timer loads on the first edge seeing tx_busy low, hits the
        // limit RESP_TIMEOUT edges later, and FIN shows done one edge after that
        start_txn(5'd1, 5'd3, 1'b0, 5'd1);
        exp_to = 1'b1;
        wait_tx_drained();
        wait_done(1000);
        check("resp_timeout_cycles", done_cyc - last_fall, int'(RESP_TO) + 2);

        // Status address mismatch
        start_txn(5'd1, 5'd3, 1'b0, 5'd1);
        wait_tx_drained();
        exp_pro = 1'b1;
        exp_status = 16'h1000;
        rx_word(16'h1000, 1'b0, 1'b0);
        wait_done(500);
        check("proto_addr_flag", err_proto, 1);

        // Status with message-error bit
        start_txn(5'd1, 5'd3, 1'b0, 5'd1);
        wait_tx_drained();
        exp_pro = 1'b1;
        exp_status = 16'h0C00;
        rx_word(16'h0C00, 1'b0, 1'b0);
        wait_done(500);

        // Parity error on the second received data word
        for (int i = 0; i < 3; i++) host_write(i, 16'hEEE0 + 16'(i), 1'b1);
        start_txn(5'd1, 5'd7, 1'b1, 5'd3);
        wait_tx_drained();
        exp_status = 16'h0800;
        rx_word(16'h0800, 1'b0, 1'b0);
        model_mem[0] = 16'h1111;
        rx_word(16'h1111, 1'b1, 1'b0);
        exp_par = 1'b1;
        rx_word(16'h2222, 1'b1, 1'b1);
        wait_done(500);
        for (int i = 0; i < 3; i++) read_check(i);

        // Data word with command sync during RXD
        start_txn(5'd1, 5'd7, 1'b1, 5'd2);
        wait_tx_drained();
        exp_status = 16'h0800;
        rx_word(16'h0800, 1'b0, 1'b0);
        exp_pro = 1'b1;
        rx_word(16'h4444, 1'b0, 1'b0);
        wait_done(500);

        // Inter-word timeout after one data word
        start_txn(5'd1, 5'd7, 1'b1, 5'd2);
        wait_tx_drained();
        exp_status = 16'h0800;
        rx_word(16'h0800, 1'b0, 1'b0);
        model_mem[0] = 16'h3333;
        exp_to = 1'b1;
        rx_word(16'h3333, 1'b1, 1'b0);
        wait_done(1000);
        check("word_timeout_cycles", done_cyc - rx_cyc, int'(WORD_TO) + 2);
        read_check(0);

        // word_cnt=0 transfer interrupted by reset mid-TXD
        start_txn(5'd2, 5'd4, 1'b0, 5'd0);
        for (int i = 0; i < 2000 && tx_seen < 6; i++) @(posedge clk);
        check("txd_progress", tx_seen >= 6, 1);
        @(negedge clk);
        reset = 1'b1;
        exp_active = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx_ready", tx_ready, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);

        // Full 32-word transfer after the reset
        start_txn(5'd2, 5'd4, 1'b0, 5'd0);
        wait_tx_drained();
        exp_status = 16'h1000;
        rx_word(16'h1000, 1'b0, 1'b0);
        wait_done(500);
        check("cmd_wc0", first_tx, 16'h1080);
        check("tx_count_wc0", tx_seen, 33);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
